// File: rtl/control_sequencer_if.sv
// Bus between the hardwired control sequencer and the single-bus datapath.
// The sequencer side (master) receives IR and Stop and drives every strobe.
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IR;
    logic             Stop;

    // Fetch strobes
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;

    // ALU / result strobes
    logic             Yin;
    logic             Zin;
    logic             ZLOout;
    logic             ZHIout;
    logic             HIin;
    logic             LOin;

    // Select-and-encode controls
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;

    logic [4:0]       alu_op;
    logic             Run;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  IR, Stop,
        output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
        output Yin, Zin, ZLOout, ZHIout, HIin, LOin,
        output Gra, Grb, Grc, Rin, Rout,
        output alu_op, Run, instr_count
    );

    modport slave (
        output IR, Stop,
        input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
        input  Yin, Zin, ZLOout, ZHIout, HIin, LOin,
        input  Gra, Grb, Grc, Rin, Rout,
        input  alu_op, Run, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), decode at the end of T2, then
// execute (T3-T6) per instruction class. All outputs are registered, decoded
// from the next state so they hold glitch-free for the whole state cycle.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop, Cls3r, ClsMd, ClsUn, ClsHalt
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlo_out;
        logic zhi_out;
        logic hi_in;
        logic lo_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } strobes_t;

    // Unlisted opcodes fall through to ClsNop.
    function automatic op_class_e classify(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: classify = Cls3r;
            5'b01111, 5'b10000:                     classify = ClsMd;
            5'b10001, 5'b10010:                     classify = ClsUn;
            5'b11011:                               classify = ClsHalt;
            default:                                classify = ClsNop;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    strobes_t         strb_q, strb_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic             run_q, run_d;
    logic             retire;
    op_class_e        cls_q, cls_d;

    assign cls_q = classify(op_q);
    assign cls_d = classify(op_d);

    // Next state, opcode latch and retirement counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        retire  = 1'b0;
        unique case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2: begin
                // Opcode is captured here so execute does not depend on IR afterwards.
                op_d = bus.IR[31:27];
                unique case (classify(bus.IR[31:27]))
                    Cls3r, ClsMd, ClsUn: state_d = StT3;
                    ClsHalt:             state_d = StHalt;
                    default:             retire  = 1'b1;
                endcase
            end
            StT3:   state_d = StT4;
            StT4: begin
                if (cls_q == ClsUn) begin
                    retire = 1'b1;
                end else begin
                    state_d = StT5;
                end
            end
            StT5: begin
                if (cls_q == Cls3r) begin
                    retire = 1'b1;
                end else begin
                    state_d = StT6;
                end
            end
            StT6:   retire  = 1'b1;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
        // Stop only matters on an instruction boundary.
        if (retire) begin
            count_d = count_q + 1'b1;
            state_d = bus.Stop ? StHalt : StT0;
        end
    end

    // Output decode for the state about to be entered.
    always_comb begin
        strb_d   = '0;
        alu_op_d = '0;
        run_d    = !(state_d inside {StRst, StHalt});
        unique case (state_d)
            StT0: begin
                strb_d.pc_out = 1'b1;
                strb_d.mar_in = 1'b1;
                strb_d.inc_pc = 1'b1;
                strb_d.z_in   = 1'b1;
            end
            StT1: begin
                strb_d.zlo_out = 1'b1;
                strb_d.pc_in   = 1'b1;
                strb_d.read    = 1'b1;
                strb_d.mdr_in  = 1'b1;
            end
            StT2: begin
                strb_d.mdr_out = 1'b1;
                strb_d.ir_in   = 1'b1;
            end
            StT3: begin
                case (cls_d)
                    Cls3r: begin
                        strb_d.grb   = 1'b1;
                        strb_d.r_out = 1'b1;
                        strb_d.y_in  = 1'b1;
                    end
                    ClsMd: begin
                        strb_d.gra   = 1'b1;
                        strb_d.r_out = 1'b1;
                        strb_d.y_in  = 1'b1;
                    end
                    ClsUn: begin
                        strb_d.grb   = 1'b1;
                        strb_d.r_out = 1'b1;
                        strb_d.z_in  = 1'b1;
                        alu_op_d     = op_d;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (cls_d)
                    Cls3r: begin
                        strb_d.grc   = 1'b1;
                        strb_d.r_out = 1'b1;
                        strb_d.z_in  = 1'b1;
                        alu_op_d     = op_d;
                    end
                    ClsMd: begin
                        strb_d.grb   = 1'b1;
                        strb_d.r_out = 1'b1;
                        strb_d.z_in  = 1'b1;
                        alu_op_d     = op_d;
                    end
                    ClsUn: begin
                        strb_d.zlo_out = 1'b1;
                        strb_d.gra     = 1'b1;
                        strb_d.r_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                if (cls_d == Cls3r) begin
                    strb_d.zlo_out = 1'b1;
                    strb_d.gra     = 1'b1;
                    strb_d.r_in    = 1'b1;
                end else begin
                    strb_d.zlo_out = 1'b1;
                    strb_d.lo_in   = 1'b1;
                end
            end
            StT6: begin
                strb_d.zhi_out = 1'b1;
                strb_d.hi_in   = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs; synchronous reset aborts any instruction.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StRst;
            op_q     <= '0;
            count_q  <= '0;
            strb_q   <= '0;
            alu_op_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            strb_q   <= strb_d;
            alu_op_q <= alu_op_d;
            run_q    <= run_d;
        end
    end

    assign bus.PCout       = strb_q.pc_out;
    assign bus.PCin        = strb_q.pc_in;
    assign bus.IncPC       = strb_q.inc_pc;
    assign bus.MARin       = strb_q.mar_in;
    assign bus.Read        = strb_q.read;
    assign bus.MDRin       = strb_q.mdr_in;
    assign bus.MDRout      = strb_q.mdr_out;
    assign bus.IRin        = strb_q.ir_in;
    assign bus.Yin         = strb_q.y_in;
    assign bus.Zin         = strb_q.z_in;
    assign bus.ZLOout      = strb_q.zlo_out;
    assign bus.ZHIout      = strb_q.zhi_out;
    assign bus.HIin        = strb_q.hi_in;
    assign bus.LOin        = strb_q.lo_in;
    assign bus.Gra         = strb_q.gra;
    assign bus.Grb         = strb_q.grb;
    assign bus.Grc         = strb_q.grc;
    assign bus.Rin         = strb_q.r_in;
    assign bus.Rout        = strb_q.r_out;
    assign bus.alu_op      = alu_op_q;
    assign bus.Run         = run_q;
    assign bus.instr_count = count_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sequences fetch and execute for the single-bus datapath.
- Replaces the hand-driven per-phase control sequencing used in the datapath benches.
- Takes IR from the datapath and emits the register-transfer strobes (PCout, MARin, IncPC, Zin, ZLOout, Yin, IRin, ...) one state per clock.
- Register selection goes through the select-and-encode block via Gra/Grb/Grc with Rin/Rout.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Stop  in  1  request halt at instruction boundary
- IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes
- Yin, Zin, ZLOout, ZHIout, HIin, LOin  out  1 each  ALU/result strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls
- alu_op  out  5  operation to ALU; equals IR[31:27] in ALU-execute states, else 0
- Run  out  1  high while sequencing, low in RST/HALT
- instr_count  out  CNT_W  instructions retired, wraps to 0

Behaviour:
- Moore FSM: all outputs decode from the registered state (plus IR fields), are glitch-free, and hold for the full state cycle. One state per clock.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Reset=1 at a rising edge moves the FSM to RST from any state, including mid-instruction; the instruction is aborted.
- In RST: all strobes 0, alu_op=0, Run=0, instr_count=0.
- RST -> T0 on the first edge with Reset=0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Decode happens on the T2->next transition using the IR value latched at the end of T2.
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110
  - mul 01111, div 10000
  - neg 10001, not 10010
  - nop 11010, halt 11011
  - any other opcode executes as nop.
- 3-register ops (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op=opcode, Zin.
  - T5: ZLOout, Gra, Rin.
  - Total 6 cycles.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_op, Zin.
  - T5: ZLOout, LOin.
  - T6: ZHIout, HIin.
  - Total 7 cycles.
- neg/not:
  - T3: Grb, Rout, alu_op, Zin.
  - T4: ZLOout, Gra, Rin.
  - Total 5 cycles.
- nop/unknown: T2 -> T0. Total 3 cycles.
- halt: T2 -> HALT. HALT asserts no strobes, Run=0, and exits only via Reset. halt does not increment instr_count.
- Retirement: on the transition out of an instruction's last state, instr_count increments by 1 (wraps at 2^CNT_W).
- Stop:
  - Sampled only at the last state of an instruction.
  - Stop=1 there -> HALT instead of T0, still counting the retired instruction.
  - Stop during other states is ignored.
- Reset and Stop high together: Reset wins.
- Run=1 in T0..T6.

Test Plan:
- Reset held 2 cycles, then released -> all strobes 0, Run=0, instr_count=0 while held; T0 one cycle after release with PCout=MARin=IncPC=Zin=1, Run=1.
- IR=0x18918000 (add R1,R2,R3) -> cycles T0..T5 in order; T3 Grb+Rout+Yin, T4 Grc+Rout+Zin with alu_op=00011, T5 ZLOout+Gra+Rin; back in T0 on cycle 7; instr_count=1.
- IR=0x80900000 (div R1,R2) -> T3 Gra+Rout+Yin, T4 alu_op=10000+Zin, T5 ZLOout+LOin, T6 ZHIout+HIin; 7-cycle instruction.
- IR=0x8A280000 (neg R4,R5) then IR=0xD0000000 (nop) -> 5-cycle then 3-cycle instructions; instr_count=2; alu_op=0 in every non-execute state.
- IR=0xD8000000 (halt) -> HALT after T2; Run=0; all strobes 0 for 20+ cycles; instr_count unchanged; only Reset restarts at T0.
- Stop pulsed during T3 of add, then high during T5 -> T3 pulse ignored; HALT after T5 with instr_count incremented. Separately, Reset asserted in T4 of mul -> RST next edge, LOin/HIin never asserted.
